// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: turns one host command into load_a/load_b/exec strobes for a byte-wide ALU and holds the result for the host
module alu_cmd_driver #(
    parameter int RESULT_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_op_a,
    input  logic [7:0] cmd_op_b,
    input  logic [3:0] cmd_opcode,
    output logic [7:0] alu_in,
    output logic [7:0] ctrl_in,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WAIT, HOLD} state_t;

    localparam logic [3:0] LAT = 4'(RESULT_LATENCY);

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [3:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] res_q, res_d;

    // state, latched command, wait counter and captured result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // next state and per-state ALU strobes; WAIT ends when the counter loaded in EXEC reaches 1
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        cmd_ready = 1'b0;
        alu_in    = '0;
        ctrl_in   = '0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    a_d     = cmd_op_a;
                    b_d     = cmd_op_b;
                    op_d    = cmd_opcode;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                alu_in  = a_q;
                ctrl_in = 8'h01;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                alu_in  = b_q;
                ctrl_in = 8'h02;
                state_d = EXEC;
            end
            EXEC: begin
                ctrl_in = {2'b01, op_q, 2'b00};
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = alu_out;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                state_d   = res_ready ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = state_q != IDLE;
    assign res_data = res_q;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: latency-2, 1 and 15 drivers against a behavioural ALU, table vectors plus scoreboard
module tb_alu_cmd_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] opa = '0;
    logic [7:0] opb = '0;
    logic [3:0] opc = '0;
    logic cv[3], cr[3], rv[3], rr[3], bz[3];
    logic [7:0] ai_w[3], ctrl_w[3], ao_w[3], rd_w[3];
    logic b2b[3];
    int last_acc[3];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [7:0] q[3][$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        int         hold;
        logic [7:0] res;
    } vec_t;
    vec_t tv[6];

    always #5 clk = ~clk;

    function automatic int lat(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 15;
    endfunction

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return (op == 4'h3) ? a + b : a - b + {4'h0, op};
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        logic [7:0] a_r, b_r;
        logic [15:0] vp;
        logic [7:0] dp [16];
        // ALU model: result of the exec strobe is visible on alu_out only during cycle L after EXEC
        always @(posedge clk) begin
            if (ctrl_w[g][0]) a_r <= ai_w[g];
            if (ctrl_w[g][1]) b_r <= ai_w[g];
            vp <= rst ? 16'h0 : {vp[14:0], ctrl_w[g][6]};
            dp[0] <= alu_f(ctrl_w[g][5:2], a_r, b_r);
            for (int i = 1; i < 16; i++) dp[i] <= dp[i-1];
        end
        assign ao_w[g] = vp[L-1] ? dp[L-1] : 8'hEE;
        alu_cmd_driver #(.RESULT_LATENCY(L)) u_dut (
            .clk(clk), .rst(rst),
            .cmd_valid(cv[g]), .cmd_ready(cr[g]),
            .cmd_op_a(opa), .cmd_op_b(opb), .cmd_opcode(opc),
            .alu_in(ai_w[g]), .ctrl_in(ctrl_w[g]), .alu_out(ao_w[g]),
            .res_valid(rv[g]), .res_ready(rr[g]), .res_data(rd_w[g]),
            .busy(bz[g])
        );
    end

    // scoreboard: push model result on acceptance, pop on result handshake; strobe invariants every cycle
    always begin
        @(negedge clk);
        #1;
        cyc++;
        for (int g = 0; g < 3; g++) begin
            chk("ctrl_bit7", 32'(ctrl_w[g][7]), 0);
            chk("strobe_onehot", 32'($countones({ctrl_w[g][6], ctrl_w[g][1:0]}) <= 1), 1);
            if (rst) begin
                q[g].delete();
            end else begin
                if (!b2b[g]) last_acc[g] = -1;
                if (cv[g] && cr[g]) begin
                    q[g].push_back(alu_f(opc, opa, opb));
                    if (last_acc[g] >= 0) chk("spacing", cyc - last_acc[g], lat(g) + 5);
                    if (b2b[g]) last_acc[g] = cyc;
                end
                if (rv[g] && rr[g]) begin
                    if (q[g].size() == 0) chk("sb_underflow", 1, 0);
                    else chk("sb_result", rd_w[g], q[g].pop_front());
                end
            end
        end
    end

    task automatic txn(input int g, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input int hold, input logic [7:0] res);
        int n;
        n = 0;
        opa = a; opb = b; opc = op; cv[g] = 1'b1;
        while (!cr[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 100, 1);
        @(negedge clk);
        cv[g] = 1'b0; opa = ~a; opb = ~b; opc = ~op;
        if (hold < 0) rr[g] = 1'b1;
        chk("load_a_ctrl", ctrl_w[g], 8'h01);
        chk("load_a_data", ai_w[g], a);
        chk("load_a_busy", bz[g], 1);
        chk("load_a_ready", cr[g], 0);
        @(negedge clk);
        chk("load_b_ctrl", ctrl_w[g], 8'h02);
        chk("load_b_data", ai_w[g], b);
        @(negedge clk);
        chk("exec_ctrl", ctrl_w[g], {2'b01, op, 2'b00});
        chk("exec_data", ai_w[g], 0);
        for (int i = 0; i < lat(g); i++) begin
            @(negedge clk);
            chk("wait_ctrl", ctrl_w[g], 0);
            chk("wait_data", ai_w[g], 0);
            chk("wait_valid", rv[g], 0);
        end
        @(negedge clk);
        chk("hold_valid", rv[g], 1);
        chk("hold_data", rd_w[g], res);
        chk("hold_ready", cr[g], 0);
        chk("hold_busy", bz[g], 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stall_valid", rv[g], 1);
            chk("stall_data", rd_w[g], res);
            chk("stall_ready", cr[g], 0);
            chk("stall_busy", bz[g], 1);
        end
        rr[g] = 1'b1;
        @(negedge clk);
        rr[g] = 1'b0;
        chk("done_valid", rv[g], 0);
        chk("done_ready", cr[g], 1);
        chk("done_busy", bz[g], 0);
        chk("done_data", rd_w[g], res);
    endtask

    task automatic b2b_run(input int g);
        int n;
        b2b[g] = 1'b1; rr[g] = 1'b1; cv[g] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            opa = tv[k].a; opb = tv[k].b; opc = tv[k].op;
            n = 0;
            while (!cr[g] && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_accept_wait", n < 100, 1);
            @(negedge clk);
        end
        cv[g] = 1'b0;
        n = 0;
        while (bz[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drain_wait", n < 100, 1);
        rr[g] = 1'b0; b2b[g] = 1'b0;
    endtask

    task automatic chk_reset_vals(input int g);
        chk("rst_ready", cr[g], 1);
        chk("rst_busy", bz[g], 0);
        chk("rst_valid", rv[g], 0);
        chk("rst_alu_in", ai_w[g], 0);
        chk("rst_ctrl", ctrl_w[g], 0);
        chk("rst_res_data", rd_w[g], 0);
    endtask

    initial begin
        tv[0] = '{8'h12, 8'h34, 4'h3, 0, 8'h46};
        tv[1] = '{8'hFF, 8'h01, 4'h3, 2, 8'h00};
        tv[2] = '{8'h50, 8'h20, 4'h0, 10, 8'h30};
        tv[3] = '{8'h20, 8'h50, 4'h1, 1, 8'hD1};
        tv[4] = '{8'h00, 8'hFF, 4'hF, -1, 8'h10};
        tv[5] = '{8'hA5, 8'h5A, 4'h7, 3, 8'h52};
        for (int g = 0; g < 3; g++) begin
            cv[g] = 1'b0; rr[g] = 1'b0; b2b[g] = 1'b0;
        end
        cv[0] = 1'b1; rr[0] = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) chk_reset_vals(g);
        cv[0] = 1'b0; rr[0] = 1'b0; rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) txn(0, tv[i].a, tv[i].b, tv[i].op, tv[i].hold, tv[i].res);

        opa = 8'h11; opb = 8'h22; opc = 4'h3; cv[0] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("pending_ready", cr[0], 0);
            opa = 8'($urandom); opb = 8'($urandom); opc = 4'($urandom);
            @(negedge clk);
        end
        chk("pending_hold_valid", rv[0], 1);
        chk("pending_hold_data", rd_w[0], 8'h33);
        chk("pending_hold_ready", cr[0], 0);
        opa = 8'($urandom); opb = 8'($urandom); rr[0] = 1'b1;
        @(negedge clk);
        rr[0] = 1'b0;
        chk("pending_first_idle", cr[0], 1);
        txn(0, 8'h33, 8'h44, 4'h3, 0, 8'h77);

        opa = 8'h5C; opb = 8'h3A; opc = 4'h3; cv[0] = 1'b1;
        @(negedge clk);
        cv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_wait", bz[0] && !rv[0] && ctrl_w[0] == 8'h00, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals(0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_valid", rv[0], 0);
            chk("abort_idle", bz[0], 0);
        end
        txn(0, 8'h5C, 8'h3A, 4'h3, 0, 8'h96);

        b2b_run(0);
        b2b_run(1);

        txn(1, tv[0].a, tv[0].b, tv[0].op, tv[0].hold, tv[0].res);
        txn(1, tv[3].a, tv[3].b, tv[3].op, tv[3].hold, tv[3].res);
        txn(2, tv[2].a, tv[2].b, tv[2].op, 0, tv[2].res);
        txn(2, tv[5].a, tv[5].b, tv[5].op, -1, tv[5].res);

        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) chk("sb_empty", q[g].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 SHALL have parameter RESULT_LATENCY, default 2, meaning cycles from exec strobe to valid alu_out (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  host command present.
REQ-005 SHALL have port cmd_ready  output  1  driver accepts command this cycle.
REQ-006 SHALL have port cmd_op_a  input  8  operand A.
REQ-007 SHALL have port cmd_op_b  input  8  operand B.
REQ-008 SHALL have port cmd_opcode  input  4  ALU opcode.
REQ-009 SHALL have port alu_in  output  8  operand byte to ALU.
REQ-010 SHALL have port ctrl_in  output  8  ALU control byte: [0] load_a, [1] load_b, [5:2] opcode, [6] exec, [7] always 0.
REQ-011 SHALL have port alu_out  input  8  ALU result byte.
REQ-012 SHALL have port res_valid  output  1  result held for host.
REQ-013 SHALL have port res_ready  input  1  host takes result.
REQ-014 SHALL have port res_data  output  8  captured result.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, EXEC, WAIT, HOLD.
REQ-017 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on the cycle cmd_valid and cmd_ready are both 1, and cmd_op_a, cmd_op_b and cmd_opcode are registered on that cycle.
REQ-018 SHALL go IDLE->LOAD_A on acceptance; LOAD_A drives alu_in=A and ctrl_in=8'h01 for exactly 1 cycle.
REQ-019 SHALL go LOAD_A->LOAD_B; LOAD_B drives alu_in=B and ctrl_in=8'h02 for exactly 1 cycle.
REQ-020 SHALL go LOAD_B->EXEC; EXEC drives ctrl_in={1'b0,1'b1,opcode,2'b00} for exactly 1 cycle, with alu_in=8'h00.
REQ-021 SHALL go EXEC->WAIT and stay in WAIT for RESULT_LATENCY cycles, counted by a 4-bit down-counter; in WAIT ctrl_in=8'h00 and alu_in=8'h00.
REQ-022 SHALL sample alu_out into res_data on the last WAIT cycle (RESULT_LATENCY cycles after the EXEC cycle) and enter HOLD with res_valid=1 on the next cycle.
REQ-023 SHALL keep res_valid=1 and res_data stable in HOLD until res_ready=1; on that cycle go HOLD->IDLE, with res_valid=0 on the next cycle.
REQ-024 SHALL accept res_ready asserted before res_valid without effect; res_ready outside HOLD is ignored.
REQ-025 SHALL ignore cmd_valid outside IDLE; no command is queued or dropped silently, because the host must hold cmd_valid until cmd_ready.
REQ-026 SHALL NOT accept a new command on the HOLD->IDLE cycle; minimum command-to-command spacing is RESULT_LATENCY+5 cycles.
REQ-027 SHALL drive ctrl_in bit 7 to 0 at all times, and SHALL never assert more than one of load_a, load_b and exec in the same cycle.
REQ-028 SHALL hold res_data at its last captured value after the handshake, until the next capture.

Reset
REQ-029 SHALL, while rst=1 at a clk edge, go to IDLE and drive cmd_ready=1 after the edge, plus alu_in=0, ctrl_in=0, res_valid=0, res_data=0, busy=0 and wait counter=0.
REQ-030 SHALL, when rst is asserted mid-operation (any state), abort the operation and discard it without asserting res_valid.
REQ-031 SHALL have rst take priority over cmd_valid and res_ready on the same edge.

Verification
REQ-032 SHALL be checked by this scenario: reset, then command A=8'h12, B=8'h34, opcode=4'h3, RESULT_LATENCY=2, ALU model returns 8'h46 -> ctrl_in sequence 01,02,4C,00,00; res_valid=1 with res_data=8'h46 on the cycle after the second WAIT cycle.
REQ-033 SHALL be checked by this scenario: res_ready held 0 for 10 cycles in HOLD -> res_valid and res_data are stable for all 10 cycles, busy=1 and cmd_ready=0; res_ready=1 -> IDLE next cycle.
REQ-034 SHALL be checked by this scenario: cmd_valid held 1 with a second command during LOAD_B..HOLD -> that command is accepted only in the first IDLE cycle, and its operands are taken at that cycle.
REQ-035 SHALL be checked by this scenario: rst pulsed 1 cycle during WAIT -> next cycle all outputs are at reset values, no res_valid pulse, and a following command completes normally.
REQ-036 SHALL be checked by this scenario: back-to-back commands with res_ready tied to 1 -> each transaction takes exactly RESULT_LATENCY+5 cycles and the results match the ALU model in order.
REQ-037 SHALL be checked by this scenario: RESULT_LATENCY=1 and RESULT_LATENCY=15 builds -> capture happens exactly 1 and 15 cycles after EXEC respectively.
